// File: rtl/palette_pkg.sv
// Shared constants, init FSM state type and optional default colour table for the palette RAM.
// Optional feature macro: PALETTE_DEFAULT_INIT_EN (per-bank default colours loaded at init).
package palette_pkg;

    localparam int unsigned SPEC_OFS = 0;
    localparam int unsigned DATA_OFS = 1;

    localparam logic [7:0]  LOCKED_RD  = 8'hFF;
    localparam logic [15:0] INIT_WHITE = 16'h7FFF;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } init_state_e;

`ifdef PALETTE_DEFAULT_INIT_EN
    // Four-shade ramp repeated across every palette; bank 0 is BG, other banks use the OBJ ramp.
    function automatic logic [15:0] default_color(input int unsigned bank, input int unsigned entry);
        logic [1:0] shade;
        shade = entry[1:0];
        if (bank == 0) begin
            case (shade)
                2'd0:    default_color = 16'h6FFB;
                2'd1:    default_color = 16'h4E73;
                2'd2:    default_color = 16'h2D6B;
                default: default_color = 16'h0C63;
            endcase
        end else begin
            case (shade)
                2'd0:    default_color = 16'h7FFF;
                2'd1:    default_color = 16'h56B5;
                2'd2:    default_color = 16'h294A;
                default: default_color = 16'h0000;
            endcase
        end
    endfunction
`endif

endpackage

// File: rtl/palette_bank.sv
// One palette bank: byte storage, spec register with auto-increment, registered PPU colour read.
// Init colour source is selected by PALETTE_DEFAULT_INIT_EN in the top level.
module palette_bank
    import palette_pkg::*;
#(
    parameter int unsigned PAL_W = 3,
    parameter int unsigned COL_W = 2
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET_L,
    input  logic                     init_busy,
    input  logic                     cpu_block,
    input  logic                     spec_we,
    input  logic                     data_we,
    input  logic [7:0]               wr_data,
    input  logic [PAL_W+COL_W-1:0]   init_entry,
    input  logic [15:0]              init_color,
    input  logic [PAL_W-1:0]         pal_sel,
    input  logic [COL_W-1:0]         color_idx,
    output logic [7:0]               spec_rd_c,
    output logic [7:0]               data_rd_c,
    output logic [15:0]              ppu_color
);

    localparam int unsigned IDX_W = PAL_W + COL_W + 1;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [7:0]       mem [DEPTH];
    logic             inc;
    logic [IDX_W-1:0] idx;

    // Spec register; the index keeps advancing on data writes even when the store is locked out.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            inc <= 1'b0;
            idx <= '0;
        end else if (!init_busy) begin
            if (spec_we) begin
                inc <= wr_data[7];
                idx <= wr_data[IDX_W-1:0];
            end else if (data_we && inc) begin
                idx <= IDX_W'(idx + 1'b1);
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (init_busy) begin
            mem[{init_entry, 1'b0}] <= init_color[7:0];
            mem[{init_entry, 1'b1}] <= init_color[15:8];
        end else if (data_we && !cpu_block) begin
            mem[idx] <= wr_data;
        end
    end

    // Both bytes of the colour are read in parallel; the register captures pre-write contents.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            ppu_color <= '0;
        end else begin
            ppu_color <= {mem[{pal_sel, color_idx, 1'b1}], mem[{pal_sel, color_idx, 1'b0}]};
        end
    end

    always_comb begin
        spec_rd_c            = 8'hFF;
        spec_rd_c[7]         = inc;
        spec_rd_c[IDX_W-1:0] = idx;
    end

    assign data_rd_c = cpu_block ? LOCKED_RD : mem[idx];

endmodule

// File: rtl/cgb_palette_ram.sv
// Colour GPU palette RAM: CPU spec/data register pairs per bank, post-reset initialiser, PPU lookup.
// Define PALETTE_DEFAULT_INIT_EN to initialise from the package default table instead of white.
module cgb_palette_ram
    import palette_pkg::*;
#(
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned PALS_PER_BANK  = 8,
    parameter int unsigned COLORS_PER_PAL = 4,
    parameter logic [15:0] BASE_ADDR      = 16'hFF68
) (
    input  logic                                          I_CLK,
    input  logic                                          I_RESET_L,
    input  logic [15:0]                                   I_MEMBUS_ADDR,
    input  logic [7:0]                                    I_DATA,
    input  logic                                          I_MEMBUS_WE_L,
    output logic [7:0]                                    O_DATA,
    output logic                                          O_IS_PAL_ADDR,
    input  logic                                          I_PPU_LOCK,
    input  logic [NUM_BANKS*$clog2(PALS_PER_BANK)-1:0]    I_PPU_PAL_SEL,
    input  logic [NUM_BANKS*$clog2(COLORS_PER_PAL)-1:0]   I_PPU_COLOR_IDX,
    output logic [NUM_BANKS*16-1:0]                       O_PPU_COLOR,
    output logic                                          O_INIT_BUSY
);

    localparam int unsigned PAL_W = $clog2(PALS_PER_BANK);
    localparam int unsigned COL_W = $clog2(COLORS_PER_PAL);
    localparam int unsigned CNT_W = PAL_W + COL_W;
    localparam int unsigned LAST  = PALS_PER_BANK * COLORS_PER_PAL - 1;

    init_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             we;
    logic             cpu_block;
    logic [NUM_BANKS-1:0] spec_hit, data_hit;
    logic [7:0]       spec_rd [NUM_BANKS];
    logic [7:0]       data_rd [NUM_BANKS];

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One colour entry per cycle across all banks, then hand the RAM to the CPU.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = CNT_W'(cnt + 1'b1);
            if (cnt == CNT_W'(LAST)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    assign O_INIT_BUSY = (state == INIT);
    assign we          = ~I_MEMBUS_WE_L;
    assign cpu_block   = I_PPU_LOCK | O_INIT_BUSY;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [15:0] SPEC_ADDR = BASE_ADDR + 16'(2 * b + SPEC_OFS);
        localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'(2 * b + DATA_OFS);

        logic [15:0] init_color;

        assign spec_hit[b] = (I_MEMBUS_ADDR == SPEC_ADDR);
        assign data_hit[b] = (I_MEMBUS_ADDR == DATA_ADDR);

`ifdef PALETTE_DEFAULT_INIT_EN
        assign init_color = default_color(b, 32'(cnt));
`else
        assign init_color = INIT_WHITE;
`endif

        palette_bank #(
            .PAL_W (PAL_W),
            .COL_W (COL_W)
        ) u_bank (
            .I_CLK      (I_CLK),
            .I_RESET_L  (I_RESET_L),
            .init_busy  (O_INIT_BUSY),
            .cpu_block  (cpu_block),
            .spec_we    (we & spec_hit[b]),
            .data_we    (we & data_hit[b]),
            .wr_data    (I_DATA),
            .init_entry (cnt),
            .init_color (init_color),
            .pal_sel    (I_PPU_PAL_SEL[b*PAL_W +: PAL_W]),
            .color_idx  (I_PPU_COLOR_IDX[b*COL_W +: COL_W]),
            .spec_rd_c  (spec_rd[b]),
            .data_rd_c  (data_rd[b]),
            .ppu_color  (O_PPU_COLOR[b*16 +: 16])
        );
    end

    always_comb begin
        O_DATA        = 8'h00;
        O_IS_PAL_ADDR = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (spec_hit[b]) begin
                O_DATA        = spec_rd[b];
                O_IS_PAL_ADDR = 1'b1;
            end
            if (data_hit[b]) begin
                O_DATA        = data_rd[b];
                O_IS_PAL_ADDR = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cgb_palette_ram.sv
// Directed bench for cgb_palette_ram with default parameters.
// Expected init colours follow PALETTE_DEFAULT_INIT_EN when the bench is built with it.
module tb_cgb_palette_ram;

`ifdef PALETTE_DEFAULT_INIT_EN
    localparam logic [15:0] B0_E0  = 16'h6FFB;
    localparam logic [15:0] B0_E2  = 16'h2D6B;
    localparam logic [15:0] B0_E31 = 16'h0C63;
    localparam logic [15:0] B1_E0  = 16'h7FFF;
    localparam logic [15:0] B1_E31 = 16'h0000;
`else
    localparam logic [15:0] B0_E0  = 16'h7FFF;
    localparam logic [15:0] B0_E2  = 16'h7FFF;
    localparam logic [15:0] B0_E31 = 16'h7FFF;
    localparam logic [15:0] B1_E0  = 16'h7FFF;
    localparam logic [15:0] B1_E31 = 16'h7FFF;
`endif

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we_l;
    logic [7:0]  rdata;
    logic        is_pal;
    logic        lock;
    logic [5:0]  pal_sel;
    logic [3:0]  col_idx;
    logic [31:0] ppu_color;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0] rd;

    always #5 clk = ~clk;

    cgb_palette_ram dut (
        .I_CLK           (clk),
        .I_RESET_L       (rst_l),
        .I_MEMBUS_ADDR   (addr),
        .I_DATA          (wdata),
        .I_MEMBUS_WE_L   (we_l),
        .O_DATA          (rdata),
        .O_IS_PAL_ADDR   (is_pal),
        .I_PPU_LOCK      (lock),
        .I_PPU_PAL_SEL   (pal_sel),
        .I_PPU_COLOR_IDX (col_idx),
        .O_PPU_COLOR     (ppu_color),
        .O_INIT_BUSY     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write committed.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we_l  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        we_l  = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_l   = 1'b0;
        addr    = 16'h0000;
        wdata   = 8'h00;
        we_l    = 1'b1;
        lock    = 1'b0;
        pal_sel = 6'b111_111;
        col_idx = 4'b11_11;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ppu", ppu_color, 32'h0);
        cpu_read(16'hFF68, rd);
        check("rst_spec_rd", 32'(rd), 32'h40);
        check("rst_is_pal", 32'(is_pal), 32'd1);
        cpu_read(16'hFF6C, rd);
        check("miss_data", 32'(rd), 32'h00);
        check("miss_is_pal", 32'(is_pal), 32'd0);

        // Init length and initial contents
        rst_l = 1'b1;
        count_busy(n);
        check("init_cycles", 32'(n), 32'd32);
        @(posedge clk);
        @(negedge clk);
        check("init_b1_p7c3", 32'(ppu_color[31:16]), 32'(B1_E31));
        check("init_b0_p7c3", 32'(ppu_color[15:0]), 32'(B0_E31));

        // Auto-increment fill of bank 0 colour 0
        cpu_write(16'hFF68, 8'h80);
        cpu_write(16'hFF69, 8'hAB);
        cpu_write(16'hFF69, 8'hCD);
        cpu_read(16'hFF68, rd);
        check("inc_spec_rd", 32'(rd), 32'hC2);
        cpu_write(16'hFF68, 8'h00);
        cpu_read(16'hFF69, rd);
        check("data_rd_byte0", 32'(rd), 32'hAB);
        pal_sel = 6'b000_000;
        col_idx = 4'b00_00;
        #1;
        check("ppu_latency_old", 32'(ppu_color[15:0]), 32'(B0_E31));
        @(posedge clk);
        @(negedge clk);
        check("ppu_b0_c0", 32'(ppu_color[15:0]), 32'hCDAB);

        // Index wrap in bank 1
        cpu_write(16'hFF6A, 8'hBF);
        cpu_write(16'hFF6B, 8'h11);
        cpu_write(16'hFF6B, 8'h22);
        cpu_read(16'hFF6A, rd);
        check("wrap_spec_rd", 32'(rd), 32'hC1);
        cpu_write(16'hFF6A, 8'h00);
        cpu_read(16'hFF6B, rd);
        check("wrap_byte0", 32'(rd), 32'h22);
        cpu_write(16'hFF6A, 8'h3F);
        cpu_read(16'hFF6B, rd);
        check("wrap_byte63", 32'(rd), 32'h11);
        check("ppu_b1_c0", 32'(ppu_color[31:16]), 32'({B1_E0[15:8], 8'h22}));

        // Lockout: store suppressed, index still advances, reads return FF
        cpu_write(16'hFF68, 8'h84);
        cpu_write(16'hFF69, 8'h12);
        cpu_write(16'hFF68, 8'h84);
        lock = 1'b1;
        cpu_read(16'hFF69, rd);
        check("lock_rd", 32'(rd), 32'hFF);
        cpu_write(16'hFF69, 8'h55);
        cpu_read(16'hFF68, rd);
        check("lock_idx_adv", 32'(rd), 32'hC5);
        col_idx = 4'b00_10;
        @(posedge clk);
        @(negedge clk);
        check("lock_ppu", 32'(ppu_color[15:0]), 32'({B0_E2[15:8], 8'h12}));
        lock = 1'b0;
        cpu_write(16'hFF68, 8'h04);
        cpu_read(16'hFF69, rd);
        check("lock_no_store", 32'(rd), 32'h12);

        // Read-before-write on a same-cycle CPU write and PPU lookup
        cpu_write(16'hFF68, 8'h00);
        col_idx = 4'b00_00;
        cpu_write(16'hFF69, 8'h99);
        check("rbw_old", 32'(ppu_color[15:0]), 32'hCDAB);
        @(posedge clk);
        @(negedge clk);
        check("rbw_new", 32'(ppu_color[15:0]), 32'hCD99);

        // Reset mid-init restarts from entry 0; CPU writes during init ignored
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        cpu_write(16'hFF68, 8'h85);
        cpu_write(16'hFF69, 8'h77);
        count_busy(n);
        check("restart_cycles", 32'(n + 2), 32'd32);
        cpu_read(16'hFF68, rd);
        check("init_spec_ignored", 32'(rd), 32'h40);
        cpu_write(16'hFF68, 8'h01);
        cpu_read(16'hFF69, rd);
        check("restart_byte1", 32'(rd), 32'(B0_E0[15:8]));
        @(posedge clk);
        @(negedge clk);
        check("init_data_ignored", 32'(ppu_color[15:0]), 32'(B0_E0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
